gshare_predictor_v2: RTL

Second-generation fetch-stage branch predictor for the 5-stage RV32I core: tagged direct-mapped BTB, PHT of 2-bit counters, speculative global history register with per-instruction checkpoints. Predicts next PC in F, carries prediction state down an internal F/D/E shadow pipeline, and resolves in E. On resolution it updates BTB/PHT, flags mispredicts and repairs the GHR. Generalises the old fixed 5-bit gshare: configurable depths, selectable bimodal/gshare mode, in-block misprediction detection.

---
 rtl/gshare_predictor_v2.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/gshare_predictor_v2.sv
// Fetch-stage branch predictor with a tagged direct-mapped BTB, a PHT of 2-bit
// counters and a speculative global history register. Each fetch carries its
// prediction and history checkpoint down an internal F/D/E shadow pipeline. The
// entry resolves in E, where the predictor updates its tables and repairs the
// history on a mispredict.
//
// Ports:
//   clk, reset_i       clock, asynchronous active-high reset
//   pc_f_i, op_f_i     F-stage PC and opcode
//   stall_f_i          hold F-stage instruction and GHR
//   stall_d_i          hold D shadow entry
//   flush_d_i          invalidate D shadow entry
//   flush_e_i          invalidate E shadow entry
//   nextpc_f_o         predicted next PC (combinational)
//   taken_f_o          predicted redirect (combinational)
//   pc_e_i             E-stage PC
//   target_e_i         resolved target
//   taken_e_i          resolved direction
//   mispredict_e_o     E-stage mispredict (combinational)
//   ghr_o              current speculative history (debug)
module gshare_predictor_v2 #(
    parameter int unsigned NUM_GHR_BITS    = 5,
    parameter int unsigned NUM_PHT_BITS    = 7,
    parameter int unsigned NUM_BTB_ENTRIES = 32,
    parameter int unsigned MODE            = 1
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic [31:0]             pc_f_i,
    input  logic [6:0]              op_f_i,
    input  logic                    stall_f_i,
    input  logic                    stall_d_i,
    input  logic                    flush_d_i,
    input  logic                    flush_e_i,
    output logic [31:0]             nextpc_f_o,
    output logic                    taken_f_o,
    input  logic [31:0]             pc_e_i,
    input  logic [31:0]             target_e_i,
    input  logic                    taken_e_i,
    output logic                    mispredict_e_o,
    output logic [NUM_GHR_BITS-1:0] ghr_o
);

    localparam int unsigned BTB_IDX_W = $clog2(NUM_BTB_ENTRIES);
    localparam int unsigned TAG_W     = 32 - BTB_IDX_W - 2;
    localparam int unsigned PHT_N     = 1 << NUM_PHT_BITS;
    localparam int unsigned G         = NUM_GHR_BITS;
    localparam int unsigned P         = NUM_PHT_BITS;

    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_JAL    = 7'd111;

    // Per-instruction prediction state carried from F down to E
    typedef struct packed {
        logic          valid;
        logic          is_b;
        logic          is_j;
        logic          pred_taken;
        logic [31:0]   pred_nextpc;
        logic [P-1:0]  pht_idx;
        logic [G-1:0]  ghr;
    } shadow_t;

    logic                 btb_valid  [NUM_BTB_ENTRIES];
    logic [TAG_W-1:0]     btb_tag    [NUM_BTB_ENTRIES];
    logic [31:0]          btb_target [NUM_BTB_ENTRIES];
    logic                 btb_is_j   [NUM_BTB_ENTRIES];
    logic                 btb_is_b   [NUM_BTB_ENTRIES];
    logic [1:0]           pht        [PHT_N];

    logic [G-1:0]         ghr_q, ghr_d;
    shadow_t              d_q, d_d, e_q, e_d, f_entry;

    logic [BTB_IDX_W-1:0] btb_idx_f, btb_idx_e;
    logic [TAG_W-1:0]     tag_f, tag_e;
    logic                 hit_f;
    logic [P-1:0]         pht_idx_f;
    logic                 pred_dir_f;
    logic                 is_b_f, is_j_f;
    logic [G-1:0]         ghr_shift_f, ghr_repair_b;
    logic                 pht_upd, btb_wr;
    logic [1:0]           pht_cur, pht_next;
    logic                 unused_pc_lsbs;

    assign unused_pc_lsbs = ^{pc_f_i[1:0], pc_e_i[1:0]};

    // F-stage lookup; reads see pre-write table contents
    assign btb_idx_f  = pc_f_i[BTB_IDX_W+1:2];
    assign tag_f      = pc_f_i[31:BTB_IDX_W+2];
    assign hit_f      = btb_valid[btb_idx_f] && (btb_tag[btb_idx_f] == tag_f);
    assign pht_idx_f  = (MODE == 1) ? (pc_f_i[P+1:2] ^ P'(ghr_q)) : pc_f_i[P+1:2];
    assign pred_dir_f = pht[pht_idx_f][1];
    assign is_b_f     = (op_f_i == OP_BRANCH);
    assign is_j_f     = (op_f_i == OP_JAL) || (op_f_i == OP_JALR);

    assign taken_f_o  = hit_f & (btb_is_j[btb_idx_f] | (btb_is_b[btb_idx_f] & pred_dir_f));
    assign nextpc_f_o = taken_f_o ? btb_target[btb_idx_f] : (pc_f_i + 32'd4);
    assign ghr_o      = ghr_q;

    // History shift/repair helpers; a 1-bit history has no older bits to keep
    generate
        if (G == 1) begin : g_ghr_one
            assign ghr_shift_f  = pred_dir_f & hit_f;
            assign ghr_repair_b = taken_e_i;
        end else begin : g_ghr_multi
            assign ghr_shift_f  = {ghr_q[G-2:0], pred_dir_f & hit_f};
            assign ghr_repair_b = {e_q.ghr[G-2:0], taken_e_i};
        end
    endgenerate

    // E-stage resolution
    assign mispredict_e_o = e_q.valid & (e_q.is_b | e_q.is_j) &
                            ((e_q.pred_taken != taken_e_i) |
                             (taken_e_i & (e_q.pred_nextpc != target_e_i)));
    assign pht_upd   = e_q.valid & e_q.is_b;
    assign btb_wr    = e_q.valid & (e_q.is_j | (e_q.is_b & taken_e_i));
    assign btb_idx_e = pc_e_i[BTB_IDX_W+1:2];
    assign tag_e     = pc_e_i[31:BTB_IDX_W+2];

    // Saturating 2-bit counter step
    always_comb begin
        pht_cur  = pht[e_q.pht_idx];
        pht_next = pht_cur;
        if (taken_e_i) begin
            if (pht_cur != 2'b11) pht_next = pht_cur + 2'd1;
        end else begin
            if (pht_cur != 2'b00) pht_next = pht_cur - 2'd1;
        end
    end

    // History next-state: mispredict repair beats the F-stage shift
    always_comb begin
        ghr_d = ghr_q;
        if (mispredict_e_o) begin
            ghr_d = e_q.is_b ? ghr_repair_b : e_q.ghr;
        end else if (is_b_f && !stall_f_i) begin
            ghr_d = ghr_shift_f;
        end
    end

    // Shadow pipeline next-state
    always_comb begin
        f_entry             = '0;
        f_entry.valid       = 1'b1;
        f_entry.is_b        = is_b_f;
        f_entry.is_j        = is_j_f;
        f_entry.pred_taken  = taken_f_o;
        f_entry.pred_nextpc = nextpc_f_o;
        f_entry.pht_idx     = pht_idx_f;
        f_entry.ghr         = ghr_q;

        d_d = d_q;
        if (mispredict_e_o || flush_d_i) begin
            d_d = '0;
        end else if (stall_d_i) begin
            d_d = d_q;
        end else if (stall_f_i) begin
            d_d = '0;
        end else begin
            d_d = f_entry;
        end

        e_d = d_q;
        if (mispredict_e_o || flush_e_i || stall_d_i) begin
            e_d = '0;
        end
    end

    // History and shadow registers
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            ghr_q <= '0;
            d_q   <= '0;
            e_q   <= '0;
        end else begin
            ghr_q <= ghr_d;
            d_q   <= d_d;
            e_q   <= e_d;
        end
    end

    // PHT storage, reset to weakly not-taken
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(PHT_N); i++) begin
                pht[i] <= 2'b01;
            end
        end else if (pht_upd) begin
            pht[e_q.pht_idx] <= pht_next;
        end
    end

    // BTB storage; a write simply overwrites whatever occupies the slot
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(NUM_BTB_ENTRIES); i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_is_j[i]   <= 1'b0;
                btb_is_b[i]   <= 1'b0;
            end
        end else if (btb_wr) begin
            btb_valid[btb_idx_e]  <= 1'b1;
            btb_tag[btb_idx_e]    <= tag_e;
            btb_target[btb_idx_e] <= target_e_i;
            btb_is_j[btb_idx_e]   <= e_q.is_j;
            btb_is_b[btb_idx_e]   <= e_q.is_b;
        end
    end

endmodule
